// File: rtl/life_pkg.sv
// Shared types, default rules and neighbour-column helpers for the Life engine.
package life_pkg;

  // Conway defaults: born with 3 neighbours, survive with 2 or 3.
  localparam logic [8:0] RULE_B3  = 9'b000001000;
  localparam logic [8:0] RULE_S23 = 9'b000001100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_FINISH = 2'd2
  } life_state_e;

  // True when column c+d contributes a neighbour (always true on a torus).
  function automatic logic nbr_valid(input int c, input int d, input int w, input logic wrap);
    return wrap || ((c + d >= 0) && (c + d < w));
  endfunction

  // Column index of neighbour c+d, folded modulo w.
  function automatic int nbr_col(input int c, input int d, input int w);
    return (c + d + w) % w;
  endfunction

endpackage

// File: rtl/life_row_update.sv
// Combinational next-row computation for one grid row plus its popcount.
module life_row_update import life_pkg::*; #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  up_row,
  input  logic [W-1:0]  cur_row,
  input  logic [W-1:0]  dn_row,
  input  logic          wrap,
  input  logic [8:0]    birth_mask,
  input  logic [8:0]    survive_mask,
  output logic [W-1:0]  next_row,
  output logic [CW-1:0] row_pop
);

  // Count the eight neighbours of each column, apply the rule, popcount the result.
  always_comb begin
    logic [3:0] cnt;
    next_row = '0;
    row_pop  = '0;
    cnt      = '0;
    for (int c = 0; c < W; c++) begin
      cnt = '0;
      for (int d = -1; d <= 1; d++) begin
        if (nbr_valid(c, d, W, wrap)) begin
          cnt = cnt + 4'(up_row[nbr_col(c, d, W)]) + 4'(dn_row[nbr_col(c, d, W)]);
          if (d != 0) cnt = cnt + 4'(cur_row[nbr_col(c, d, W)]);
        end
      end
      next_row[c] = cur_row[c] ? survive_mask[cnt] : birth_mask[cnt];
      row_pop     = row_pop + CW'(next_row[c]);
    end
  end

endmodule

// File: rtl/life_grid_engine.sv
// Row-sequential Game of Life engine: register grid, in-place sweep, counters.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | accept clear / load / step (in that priority)
//   ST_SWEEP  | rewrite row r_q per cycle, r_q = 0..H-1
//   ST_FINISH | one-cycle done pulse, back to idle
module life_grid_engine import life_pkg::*; #(
  parameter int W     = 16,
  parameter int H     = 16,
  parameter int GEN_W = 16,
  parameter int POP_W = $clog2(W * H + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 step,
  input  logic                 wrap,
  input  logic [8:0]           birth_mask,
  input  logic [8:0]           survive_mask,
  input  logic                 load_en,
  input  logic [$clog2(H)-1:0] load_row,
  input  logic [W-1:0]         load_data,
  input  logic                 clear,
  input  logic [$clog2(H)-1:0] rd_row,
  output logic [W-1:0]         rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [GEN_W-1:0]     generation,
  output logic [POP_W-1:0]     population
);

  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W + 1);

  life_state_e      state_q, state_d;
  logic [RW-1:0]    r_q, r_d;
  logic [W-1:0]     grid_q [H];
  logic [W-1:0]     grid_d [H];
  logic [W-1:0]     prev_q, prev_d;
  logic [W-1:0]     first_q, first_d;
  logic             wrap_q, wrap_d;
  logic [8:0]       birth_q, birth_d;
  logic [8:0]       survive_q, survive_d;
  logic [POP_W-1:0] pop_acc_q, pop_acc_d;
  logic [POP_W-1:0] population_q, population_d;
  logic [GEN_W-1:0] generation_q, generation_d;
  logic [W-1:0]     rd_data_q, rd_data_d;

  logic [W-1:0]     up_row, cur_row, dn_row, next_row;
  logic [CW-1:0]    row_pop;
  logic [POP_W-1:0] pop_sum;

  // Neighbour rows for the row being swept; row r-1 is already overwritten, so use prev_q.
  always_comb begin
    cur_row = grid_q[r_q];
    up_row  = (r_q == '0) ? (wrap_q ? grid_q[H-1] : '0) : prev_q;
    if (int'(r_q) == H - 1) dn_row = wrap_q ? first_q : '0;
    else                    dn_row = grid_q[r_q + RW'(1)];
  end

  life_row_update #(.W(W), .CW(CW)) u_row (
    .up_row       (up_row),
    .cur_row      (cur_row),
    .dn_row       (dn_row),
    .wrap         (wrap_q),
    .birth_mask   (birth_q),
    .survive_mask (survive_q),
    .next_row     (next_row),
    .row_pop      (row_pop)
  );

  // Next-state, grid update and counter logic.
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    grid_d       = grid_q;
    prev_d       = prev_q;
    first_d      = first_q;
    wrap_d       = wrap_q;
    birth_d      = birth_q;
    survive_d    = survive_q;
    pop_acc_d    = pop_acc_q;
    population_d = population_q;
    generation_d = generation_q;
    pop_sum      = pop_acc_q + POP_W'(row_pop);
    rd_data_d    = (int'(rd_row) < H) ? grid_q[rd_row] : '0;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          for (int i = 0; i < H; i++) grid_d[i] = '0;
          population_d = '0;
        end else if (load_en) begin
          if (int'(load_row) < H) grid_d[load_row] = load_data;
        end else if (step) begin
          wrap_d    = wrap;
          birth_d   = birth_mask;
          survive_d = survive_mask;
          r_d       = '0;
          pop_acc_d = '0;
          state_d   = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        grid_d[r_q] = next_row;
        prev_d      = grid_q[r_q];
        if (r_q == '0) first_d = grid_q[0];
        pop_acc_d = pop_sum;
        if (int'(r_q) == H - 1) begin
          // Counters settle together with the done pulse.
          population_d = pop_sum;
          generation_d = generation_q + GEN_W'(1);
          state_d      = ST_FINISH;
        end else begin
          r_d = r_q + RW'(1);
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including a partial sweep.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      r_q          <= '0;
      grid_q       <= '{default: '0};
      prev_q       <= '0;
      first_q      <= '0;
      wrap_q       <= 1'b0;
      birth_q      <= RULE_B3;
      survive_q    <= RULE_S23;
      pop_acc_q    <= '0;
      population_q <= '0;
      generation_q <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      grid_q       <= grid_d;
      prev_q       <= prev_d;
      first_q      <= first_d;
      wrap_q       <= wrap_d;
      birth_q      <= birth_d;
      survive_q    <= survive_d;
      pop_acc_q    <= pop_acc_d;
      population_q <= population_d;
      generation_q <= generation_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign busy       = (state_q == ST_SWEEP);
  assign done       = (state_q == ST_FINISH);
  assign rd_data    = rd_data_q;
  assign generation = generation_q;
  assign population = population_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: whole-grid reference model plus per-cycle compare.
module tb_life_grid_engine;
  import life_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int PW = $clog2(W * H + 1);

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          step = 1'b0;
  logic          wrap = 1'b0;
  logic [8:0]    birth_mask = RULE_B3;
  logic [8:0]    survive_mask = RULE_S23;
  logic          load_en = 1'b0;
  logic [2:0]    load_row = '0;
  logic [W-1:0]  load_data = '0;
  logic          clear = 1'b0;
  logic [2:0]    rd_row = '0;
  logic [W-1:0]  rd_data;
  logic          busy, done;
  logic [15:0]   generation;
  logic [PW-1:0] population;

  life_grid_engine #(.W(W), .H(H), .GEN_W(16)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .step(step), .wrap(wrap),
    .birth_mask(birth_mask), .survive_mask(survive_mask),
    .load_en(load_en), .load_row(load_row), .load_data(load_data),
    .clear(clear), .rd_row(rd_row), .rd_data(rd_data),
    .busy(busy), .done(done), .generation(generation), .population(population)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: whole grid, phase k (0 idle, 1..H sweeping, H+1 done cycle).
  logic [W-1:0] mgrid [H];
  logic [W-1:0] ngrid [H];
  int           k = 0;
  int           exp_gen = 0;
  int           exp_pop = 0;
  logic         exp_busy = 1'b0, exp_done = 1'b0;
  logic [W-1:0] exp_rd = '0;
  logic         rd_ok = 1'b0;
  logic         chk_en = 1'b0;
  int           n_checks = 0;
  int           n_err = 0;
  int           n_done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compute_next(input logic wr, input logic [8:0] bm, input logic [8:0] sm);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (wr) begin
              rr = (rr + H) % H;
              cc = (cc + W) % W;
            end
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < H && cc >= 0 && cc < W)
              n += int'(mgrid[rr][cc]);
          end
        end
        ngrid[r][c] = mgrid[r][c] ? sm[n] : bm[n];
      end
    end
  endtask

  function automatic int grid_pop();
    int p;
    p = 0;
    for (int r = 0; r < H; r++) p += $countones(ngrid[r]);
    return p;
  endfunction

  // One clock: capture what the edge reads, then apply the edge's effect to the model.
  task automatic tick();
    logic [W-1:0] pend;
    logic         pend_ok;
    pend    = mgrid[rd_row];
    pend_ok = (k == 0);
    @(posedge clk_in);
    #1;
    if (done) n_done_seen++;
    if (!rst_n) begin
      k = 0;
    end else if (k == 0) begin
      if (clear) begin
        for (int i = 0; i < H; i++) mgrid[i] = '0;
        exp_pop = 0;
      end else if (load_en) begin
        mgrid[load_row] = load_data;
      end else if (step) begin
        compute_next(wrap, birth_mask, survive_mask);
        k = 1;
      end
    end else if (k < H) begin
      k++;
    end else if (k == H) begin
      mgrid   = ngrid;
      exp_gen = (exp_gen + 1) % 65536;
      exp_pop = grid_pop();
      k       = H + 1;
    end else begin
      k = 0;
    end
    exp_busy = (k >= 1 && k <= H);
    exp_done = (k == H + 1);
    exp_rd   = pend;
    rd_ok    = pend_ok;
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (rd_ok) chk("rd_data", 32'(rd_data), 32'(exp_rd));
      if (k == 0) begin
        chk("generation", 32'(generation), 32'(exp_gen));
        chk("population", 32'(population), 32'(exp_pop));
      end
    end
  end

  task automatic reset_now();
    rst_n = 1'b0;
    for (int i = 0; i < H; i++) mgrid[i] = '0;
    k = 0; exp_gen = 0; exp_pop = 0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_rd = '0; rd_ok = 1'b1;
  endtask

  task automatic apply_reset();
    reset_now();
    step = 0; load_en = 0; clear = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load(input int r, input logic [W-1:0] d);
    load_en = 1'b1; load_row = 3'(r); load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 3 * H && k != 0; i++) tick();
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    run_to_idle();
  endtask

  task automatic readback();
    for (int i = 0; i < H; i++) begin
      rd_row = 3'(i);
      tick();
    end
    tick();
  endtask

  task automatic read_row(input int r, output logic [W-1:0] d);
    rd_row = 3'(r);
    tick();
    d = rd_data;
  endtask

  task automatic step_noisy(input logic wr, input logic [8:0] bm, input logic [8:0] sm);
    step = 1'b1;
    tick();
    for (int g = 0; g < 3 * H && k != 0; g++) begin
      step = 1'($urandom); load_en = 1'($urandom); clear = ($urandom_range(0, 3) == 0);
      load_row = 3'($urandom); load_data = 8'($urandom); rd_row = 3'($urandom);
      wrap = 1'($urandom); birth_mask = 9'($urandom); survive_mask = 9'($urandom);
      tick();
    end
    step = 0; load_en = 0; clear = 0;
    wrap = wr; birth_mask = bm; survive_mask = sm;
  endtask

  initial begin
    logic [W-1:0] d;
    int lat, base_done;
    logic got;
    logic [W-1:0] glider [3];
    glider[0] = 8'b00000010; glider[1] = 8'b00000100; glider[2] = 8'b00000111;
    for (int i = 0; i < H; i++) mgrid[i] = '0;
    chk_en = 1'b1;
    apply_reset();
    chk("reset_generation", 32'(generation), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Vertical blinker at column 3, rows 2..4, dead boundary.
    wrap = 0; birth_mask = RULE_B3; survive_mask = RULE_S23;
    load(2, 8'h08); load(3, 8'h08); load(4, 8'h08);
    step = 1'b1; tick(); step = 1'b0;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(); lat++;
      if (done) got = 1'b1;
    end
    chk("done_latency", 32'(lat + 1), 32'(H + 1));
    run_to_idle();
    chk("model_blinker_row3", 32'(mgrid[3]), 32'h1C);
    chk("model_blinker_row2", 32'(mgrid[2]), 32'h00);
    read_row(3, d);
    chk("dut_blinker_row3", 32'(d), 32'h1C);
    chk("blinker_pop", 32'(population), 32'd3);
    chk("blinker_gen", 32'(generation), 32'd1);
    readback();
    do_step();
    chk("model_blinker_back", 32'(mgrid[2]), 32'h08);
    read_row(4, d);
    chk("dut_blinker_back", 32'(d), 32'h08);
    readback();

    // Glider on a torus returns home after 32 generations.
    apply_reset();
    wrap = 1;
    for (int i = 0; i < 3; i++) load(i, glider[i]);
    for (int s = 0; s < 32; s++) begin
      do_step();
      chk("glider_pop", 32'(population), 32'd5);
    end
    for (int i = 0; i < 3; i++) chk("model_glider_home", 32'(mgrid[i]), 32'(glider[i]));
    chk("glider_gen", 32'(generation), 32'd32);
    readback();

    // Horizontal blinker straddling columns 7/0.
    apply_reset();
    wrap = 1;
    load(3, 8'b10000011);
    do_step();
    chk("straddle_wrap_pop1", 32'(population), 32'd3);
    do_step();
    chk("straddle_wrap_pop2", 32'(population), 32'd3);
    read_row(3, d);
    chk("straddle_wrap_row3", 32'(d), 32'h83);
    wrap = 0;
    do_step(); do_step();
    chk("straddle_dead_pop", 32'(population), 32'd0);
    readback();

    // Still-life block, then zero rule masks.
    apply_reset();
    wrap = 0;
    load(3, 8'h18); load(4, 8'h18);
    do_step();
    chk("block_pop", 32'(population), 32'd4);
    birth_mask = '0; survive_mask = '0;
    do_step();
    chk("zero_rule_pop", 32'(population), 32'd0);
    readback();
    birth_mask = RULE_B3; survive_mask = RULE_S23;

    // Step and load during a sweep are dropped.
    apply_reset();
    load(2, 8'h08); load(3, 8'h08); load(4, 8'h08);
    base_done = n_done_seen;
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick();
    step = 1'b1; tick(); step = 1'b0;
    load_en = 1'b1; load_row = 3'd0; load_data = 8'hFF; tick(); load_en = 1'b0;
    run_to_idle();
    repeat (H + 3) tick();
    chk("busy_single_done", 32'(n_done_seen - base_done), 32'd1);
    chk("busy_gen", 32'(generation), 32'd1);
    read_row(0, d);
    chk("busy_load_ignored", 32'(d), 32'h00);

    // Reset in the middle of a sweep.
    load(5, 8'hF0);
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick(); tick();
    reset_now();
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rd", 32'(rd_data), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    readback();
    load(2, 8'h08); load(3, 8'h08); load(4, 8'h08);
    do_step();
    chk("midrst_gen", 32'(generation), 32'd1);
    readback();

    // Randomised grids, rules and boundary with noise while busy.
    for (int round = 0; round < 6; round++) begin
      logic         wr;
      logic [8:0]   bm, sm;
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < H; i++) load(i, 8'($urandom));
      wr = 1'($urandom);
      bm = (round % 2 == 0) ? RULE_B3 : 9'($urandom);
      sm = (round % 2 == 0) ? RULE_S23 : 9'($urandom);
      wrap = wr; birth_mask = bm; survive_mask = sm;
      for (int s = 0; s < 3; s++) begin
        step_noisy(wr, bm, sm);
        readback();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
Parametrised, row-sequential Game of Life engine that replaces the fixed 16x16 array of per-cell automata. The grid state is held in registers. One row is updated per clock on a start/done handshake. The block adds selectable toroidal or dead boundaries, runtime-programmable birth/survive rules, row-wise load/readback, a generation counter and a population count. It sits between the generation-rate divider, which drives step, and the VGA renderer, which reads rows.

Parameters:
W, 16, grid columns (>=3)
H, 16, grid rows (>=3)
GEN_W, 16, generation counter width
POP_W, $clog2(W*H+1), population count width

Ports:
clk_in  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
step  input  1  request one generation (pulse/level, sampled in IDLE)
wrap  input  1  1 = toroidal boundary, 0 = dead cells outside grid
birth_mask  input  9  bit n set: dead cell with n live neighbours is born
survive_mask  input  9  bit n set: live cell with n live neighbours survives
load_en  input  1  write load_data into row load_row
load_row  input  $clog2(H)  target row
load_data  input  W  row contents, bit c = column c
clear  input  1  synchronous clear of whole grid
rd_row  input  $clog2(H)  readback row select
rd_data  output  W  registered contents of rd_row, 1-cycle latency
busy  output  1  high while a generation is in progress
done  output  1  1-cycle pulse when a generation completes
generation  output  GEN_W  completed-generation count
population  output  POP_W  live cells after the last completed generation

Behaviour:
- Reset (async, rst_n=0): grid all 0, state IDLE, busy=0, done=0, generation=0, population=0, rd_data=0. Applies immediately, including mid-sweep. No partial row survives.
- States: IDLE -> SWEEP -> FINISH -> IDLE.
- IDLE, priority order each cycle: clear, then load_en, then step.
  - clear: zero the grid and set population=0; generation unchanged.
  - load_en: write the row and recompute nothing; population stays stale until the next done. A step in the same cycle is dropped.
  - step: accept, latch wrap, birth_mask and survive_mask, set row index r=0, go to SWEEP. busy=1 from the next cycle.
- SWEEP: one row per cycle, r = 0..H-1.
  - Next-state of row r is computed for all W columns in parallel from old rows r-1, r and r+1.
  - Row r is overwritten in place, so the old row r is copied into prev_buf before the write.
  - Old row 0 is copied into first_buf at r=0, for wrap use at r=H-1.
  - Neighbour rows: r-1 comes from prev_buf; at r=0 it is old row H-1 if wrap=1, else zeros. r+1 comes from the live grid; at r=H-1 it is first_buf if wrap=1, else zeros.
  - Columns: c-1 and c+1 wrap modulo W when wrap=1; otherwise out-of-range neighbours are 0.
  - Rule: next = alive ? survive_mask[n] : birth_mask[n], with n in 0..8.
  - A popcount of each new row accumulates into pop_acc.
- FINISH (1 cycle): population <= pop_acc, generation <= generation+1 (wraps at 2^GEN_W), done=1. Return to IDLE; busy=0 in the same cycle as done.
- Latency: step accepted at cycle T; done asserted at T+H+1; next step accepted at T+H+2 at the earliest.
- While busy: step, load_en and clear are ignored (no queuing). Mask or wrap changes have no effect until the next acceptance.
- rd_data <= grid[rd_row] every cycle, in every state. During SWEEP a row reads new or old according to whether it has been swept yet.
- rd_row or load_row >= H: read returns 0, write is ignored.

Decomposition:
- Shared package life_pkg: default masks (B3 = 9'b000001000, S23 = 9'b000001100), state encoding, and a function giving the neighbour index with wrap.
- Sub-module life_row_update: combinational W-wide next-row and popcount from three rows plus wrap and masks.
- The parent holds the FSM, grid, buffers and counters.

Test Plan:
- 8x8, wrap=0, load vertical blinker at (3,2),(3,3),(3,4), step -> after done: cells (2,3),(3,3),(4,3); population=3; generation=1; second step restores the original; done arrives exactly H+1=9 cycles after step.
- 8x8, wrap=1, glider loaded, 32 steps -> grid equals the original pattern; generation=32; population=5 after every step.
- 8x8, blinker straddling columns 7/0 -> wrap=1 oscillates with period 2 and population 3; wrap=0 dies (population 0 after 2 steps).
- 2x2 block, then set birth_mask=0 and survive_mask=0, step -> block is still life under defaults; under the zero masks population=0 after 1 step.
- Step pulsed at T+3 and load_en at T+4 during a sweep -> both ignored; single done at T+9; generation increments by 1; grid unaltered by the load.
- rst_n low at T+4 mid-sweep -> busy, done and grid all 0 immediately; after release, step is accepted normally and generation counts from 0.
